atm_session_driver: RTL and testbench

//  Synthesizable customer-side initiator for the ATM FSM (atm_top). One start request runs a full session:

---
 rtl/atm_pkg.sv | 29 ++
 rtl/atm_step_timer.sv | 40 ++++
 rtl/atm_session_driver.sv | 186 ++++++++++++++++++
 tb/tb_atm_session_driver.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// ATM state encodings, driver FSM states and data widths shared by the session driver.
package atm_pkg;

  localparam int PIN_W  = 16;
  localparam int CASH_W = 14;

  localparam logic [2:0] ATM_S_IDLE     = 3'd0;
  localparam logic [2:0] ATM_S_CARD     = 3'd1;
  localparam logic [2:0] ATM_S_PIN      = 3'd2;
  localparam logic [2:0] ATM_S_AMOUNT   = 3'd3;
  localparam logic [2:0] ATM_S_DISPENSE = 3'd4;

  typedef enum logic [2:0] {
    DRV_IDLE,
    DRV_SETUP,
    DRV_STEP,
    DRV_WAIT,
    DRV_REPORT,
    DRV_CANCEL,
    DRV_CWAIT,
    DRV_FAIL
  } drv_state_e;

  // Steps that carry data get one quiet cycle so pin/cash_in settle before next rises.
  function automatic logic needs_setup(input logic [2:0] step);
    return (step == ATM_S_PIN) || (step == ATM_S_AMOUNT);
  endfunction

endpackage

// File: rtl/atm_step_timer.sv
// Loadable saturating step timer: load sets the count to 1 (first cycle of a step).
// hold_done_o flags NEXT_HOLD cycles elapsed, timeout_o flags TIMEOUT; the count never wraps.
module atm_step_timer #(
  parameter int NEXT_HOLD = 3,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic hold_done_o,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] HOLD_V = CNT_W'(NEXT_HOLD);
  localparam logic [CNT_W-1:0] TMO_V  = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != TMO_V) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hold_done_o = (cnt_q == HOLD_V);
  assign timeout_o   = (cnt_q == TMO_V);

endmodule

// File: rtl/atm_session_driver.sv
// Customer-side ATM initiator: one start runs card -> PIN -> amount -> dispense, then reports.
// Define ATM_DRV_RETRY_EN to re-issue a step once after its first timeout before cancelling.
module atm_session_driver
  import atm_pkg::*;
#(
  parameter int NEXT_HOLD = 3,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [PIN_W-1:0]  req_pin,
  input  logic [CASH_W-1:0] req_amount,
  input  logic [2:0]        atm_state,
  input  logic              atm_success,
  input  logic [CASH_W-1:0] atm_cash_out,
  output logic              atm_next,
  output logic              atm_cancel,
  output logic [PIN_W-1:0]  atm_pin,
  output logic [CASH_W-1:0] atm_cash_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CASH_W-1:0] cash_received,
  output logic [2:0]        err_step
);

  drv_state_e        state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [2:0]        err_q, err_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [CASH_W-1:0] amt_q, amt_d;
  logic [CASH_W-1:0] cash_q, cash_d;
  logic              tmr_load, tmr_hold_done, tmr_timeout;
  logic              unexpected, wait_fail, active;
`ifdef ATM_DRV_RETRY_EN
  logic              retry_q, retry_d;
`endif

  atm_step_timer #(
    .NEXT_HOLD (NEXT_HOLD),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (tmr_load),
    .hold_done_o (tmr_hold_done),
    .timeout_o   (tmr_timeout)
  );

  // In WAIT(n) only n-1 (not yet moved) or n (arrived) are legal ATM states.
  assign unexpected = (atm_state != step_q) && (atm_state != (step_q - 3'd1));
  assign wait_fail  = tmr_timeout || unexpected;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    err_d   = err_q;
    pin_d   = pin_q;
    amt_d   = amt_q;
    cash_d  = cash_q;
`ifdef ATM_DRV_RETRY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      DRV_IDLE: begin
        if (start && !abort) begin
          pin_d   = req_pin;
          amt_d   = req_amount;
          step_d  = ATM_S_CARD;
          state_d = DRV_STEP;
`ifdef ATM_DRV_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      DRV_SETUP: begin
        if (abort) begin
          err_d   = '0;
          state_d = DRV_CANCEL;
        end else begin
          state_d = DRV_STEP;
        end
      end
      DRV_STEP: begin
        if (abort) begin
          err_d   = '0;
          state_d = DRV_CANCEL;
        end else if (tmr_hold_done) begin
          state_d = DRV_WAIT;
        end
      end
      DRV_WAIT: begin
        if (abort) begin
          err_d   = '0;
          state_d = DRV_CANCEL;
        end else if (atm_state == step_q) begin
`ifdef ATM_DRV_RETRY_EN
          retry_d = 1'b0;
`endif
          if (step_q == ATM_S_DISPENSE) begin
            state_d = DRV_REPORT;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = needs_setup(step_q + 3'd1) ? DRV_SETUP : DRV_STEP;
          end
        end else if (wait_fail) begin
`ifdef ATM_DRV_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            state_d = needs_setup(step_q) ? DRV_SETUP : DRV_STEP;
          end else begin
            err_d   = step_q;
            state_d = DRV_CANCEL;
          end
`else
          err_d   = step_q;
          state_d = DRV_CANCEL;
`endif
        end
      end
      DRV_REPORT: begin
        cash_d  = atm_cash_out;
        state_d = DRV_IDLE;
      end
      DRV_CANCEL: begin
        if (tmr_hold_done) begin
          state_d = DRV_CWAIT;
        end
      end
      DRV_CWAIT: begin
        if ((atm_state == ATM_S_IDLE) || tmr_timeout) begin
          state_d = DRV_FAIL;
        end
      end
      DRV_FAIL: begin
        cash_d  = atm_cash_out;
        state_d = DRV_IDLE;
      end
      default: state_d = DRV_IDLE;
    endcase
    // Timer restarts on every entry into a next-hold or cancel-hold phase.
    tmr_load = ((state_d == DRV_STEP) && (state_q != DRV_STEP)) ||
               ((state_d == DRV_CANCEL) && (state_q != DRV_CANCEL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DRV_IDLE;
      step_q  <= '0;
      err_q   <= '0;
      pin_q   <= '0;
      amt_q   <= '0;
      cash_q  <= '0;
`ifdef ATM_DRV_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      err_q   <= err_d;
      pin_q   <= pin_d;
      amt_q   <= amt_d;
      cash_q  <= cash_d;
`ifdef ATM_DRV_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign active        = (state_q != DRV_IDLE);
  assign busy          = state_q inside {DRV_SETUP, DRV_STEP, DRV_WAIT, DRV_CANCEL, DRV_CWAIT};
  assign atm_next      = (state_q == DRV_STEP);
  assign atm_cancel    = (state_q == DRV_CANCEL);
  assign atm_pin       = (active && (step_q >= ATM_S_PIN)) ? pin_q : '0;
  assign atm_cash_in   = (active && (step_q >= ATM_S_AMOUNT)) ? amt_q : '0;
  assign done          = (state_q == DRV_REPORT) || (state_q == DRV_FAIL);
  assign pass          = (state_q == DRV_REPORT) && atm_success;
  assign cash_received = cash_q;
  assign err_step      = (state_q == DRV_FAIL) ? err_q :
                         ((state_q == DRV_REPORT) && !atm_success) ? ATM_S_DISPENSE : 3'd0;

endmodule

// File: tb/tb_atm_session_driver.sv
// Directed bench: session driver paired with a behavioural ATM model (edge-triggered next, delayed response).
module tb_atm_session_driver;

  localparam int          NH       = 3;
  localparam int          TMO      = 64;
  localparam logic [15:0] GOOD_PIN = 16'h5612;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] req_pin = '0;
  logic [13:0] req_amount = '0;
  logic [2:0]  atm_state;
  logic        atm_success;
  logic [13:0] atm_cash_out;
  logic        atm_next, atm_cancel;
  logic [15:0] atm_pin;
  logic [13:0] atm_cash_in;
  logic        busy, done, pass;
  logic [13:0] cash_received;
  logic [2:0]  err_step;

  int checks = 0;
  int fails  = 0;

  always #2 clk = ~clk;

  atm_session_driver #(.NEXT_HOLD(NH), .TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .req_pin(req_pin), .req_amount(req_amount),
    .atm_state(atm_state), .atm_success(atm_success), .atm_cash_out(atm_cash_out),
    .atm_next(atm_next), .atm_cancel(atm_cancel), .atm_pin(atm_pin), .atm_cash_in(atm_cash_in),
    .busy(busy), .done(done), .pass(pass), .cash_received(cash_received), .err_step(err_step)
  );

  // ---------------- ATM model ----------------
  logic [2:0]  m_st, m_pend;
  logic        m_succ, m_nprev;
  logic [13:0] m_cout, m_amt;
  int          m_dly;
  bit          stuck = 1'b0;
  int          atm_lat = 4;

  assign atm_state    = m_st;
  assign atm_success  = m_succ;
  assign atm_cash_out = m_cout;

  function automatic logic [2:0] atm_next_st(input logic [2:0] st, input logic [15:0] pin);
    case (st)
      3'd0: return 3'd1;
      3'd1: return (pin == GOOD_PIN) ? 3'd2 : 3'd1;
      3'd2: return 3'd3;
      3'd3: return 3'd4;
      default: return st;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st <= 3'd0; m_pend <= 3'd0; m_succ <= 1'b0; m_nprev <= 1'b0;
      m_cout <= '0; m_amt <= '0; m_dly <= 0;
    end else begin
      m_nprev <= atm_next;
      if (atm_cancel) begin
        m_st <= 3'd0; m_succ <= 1'b0; m_cout <= '0; m_dly <= 0;
      end else if (m_dly != 0) begin
        m_dly <= m_dly - 1;
        if (m_dly == 1) begin
          m_st <= m_pend;
          if (m_pend == 3'd4) begin
            m_succ <= 1'b1;
            m_cout <= m_amt;
          end
        end
      end else if (atm_next && !m_nprev) begin
        if (m_st == 3'd2) m_amt <= atm_cash_in;
        if ((atm_next_st(m_st, atm_pin) != m_st) && !(stuck && (atm_next_st(m_st, atm_pin) > 3'd1))) begin
          m_pend <= atm_next_st(m_st, atm_pin);
          m_dly  <= atm_lat;
        end
      end else if ((m_st == 3'd4) && !busy) begin
        m_st <= 3'd0; m_succ <= 1'b0; m_cout <= '0;
      end
    end
  end

  // ---------------- protocol monitor (records, tasks compare) ----------------
  logic        p_next = 1'b0, p_cancel = 1'b0;
  logic [15:0] p_pin = '0;
  logic [13:0] p_cash = '0;
  logic [2:0]  p_state = '0;
  int          n_len = 0, c_len = 0;
  int          excl_bad = 0, setup_bad = 0, len_bad = 0, cancel_rises = 0, done_cnt = 0;
  logic [15:0] rise_pin[$];
  logic [13:0] rise_cash[$];
  logic [2:0]  st_seq[$];

  always @(negedge clk) begin
    if (atm_next && atm_cancel) excl_bad <= excl_bad + 1;
    if (atm_next && !p_next) begin
      rise_pin.push_back(atm_pin);
      rise_cash.push_back(atm_cash_in);
      if ((atm_pin !== p_pin) || (atm_cash_in !== p_cash)) setup_bad <= setup_bad + 1;
    end
    if (!atm_next && p_next && (n_len != NH)) len_bad <= len_bad + 1;
    if (!atm_cancel && p_cancel && (c_len != NH)) len_bad <= len_bad + 1;
    if (atm_cancel && !p_cancel) cancel_rises <= cancel_rises + 1;
    n_len <= atm_next ? n_len + 1 : 0;
    c_len <= atm_cancel ? c_len + 1 : 0;
    if (done) done_cnt <= done_cnt + 1;
    if (atm_state != p_state) st_seq.push_back(atm_state);
    p_next <= atm_next; p_cancel <= atm_cancel;
    p_pin <= atm_pin; p_cash <= atm_cash_in; p_state <= atm_state;
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_session(input logic [15:0] pin, input logic [13:0] amt);
    @(negedge clk);
    req_pin = pin; req_amount = amt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output int cycles);
    got = 1'b0; cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1; cycles = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, atm_next, atm_cancel} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b need 00000", {busy, done, pass, atm_next, atm_cancel});
    end
    checks++;
    if ((atm_pin !== 16'd0) || (atm_cash_in !== 14'd0)) begin
      fails++; $display("FAIL reset_data: pin %h cash_in %0d need 0", atm_pin, atm_cash_in);
    end
    checks++;
    if ((cash_received !== 14'd0) || (err_step !== 3'd0)) begin
      fails++; $display("FAIL reset_report: cash %0d err %0d need 0", cash_received, err_step);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ((busy !== 1'b0) || (atm_next !== 1'b0)) begin
      fails++; $display("FAIL idle_after_reset: busy %b next %b need 0", busy, atm_next);
    end
  endtask

  task automatic test_session();
    bit got; int cyc; int sb; int rb;
    sb = st_seq.size(); rb = rise_pin.size();
    atm_lat = 4;
    start_session(GOOD_PIN, 14'd2500);
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL session_busy: got %b need 1", busy); end
    wait_done(300, got, cyc);
    checks++;
    if (!got) begin fails++; $display("FAIL session_done: no done in 300 cycles"); end
    checks++;
    if ((pass !== 1'b1) || (err_step !== 3'd0) || (busy !== 1'b0)) begin
      fails++; $display("FAIL session_report: pass %b err %0d busy %b need 1 0 0", pass, err_step, busy);
    end
    @(negedge clk);
    checks++;
    if (cash_received !== 14'd2500) begin
      fails++; $display("FAIL session_cash: got %0d need 2500", cash_received);
    end
    checks++;
    if ((atm_pin !== 16'd0) || (atm_cash_in !== 14'd0)) begin
      fails++; $display("FAIL session_data_idle: pin %h cash_in %0d need 0", atm_pin, atm_cash_in);
    end
    checks++;
    if ((st_seq.size() < sb + 4) || (st_seq[sb] !== 3'd1) || (st_seq[sb+1] !== 3'd2) ||
        (st_seq[sb+2] !== 3'd3) || (st_seq[sb+3] !== 3'd4)) begin
      fails++; $display("FAIL session_seq: %0d state changes, need 1,2,3,4", st_seq.size() - sb);
    end
    checks++;
    if (rise_pin.size() != rb + 4) begin
      fails++; $display("FAIL session_next_pulses: got %0d need 4", rise_pin.size() - rb);
    end else begin
      checks++;
      if ((rise_pin[rb] !== 16'd0) || (rise_pin[rb+1] !== GOOD_PIN) || (rise_cash[rb+1] !== 14'd0)) begin
        fails++; $display("FAIL step_pin: step1 pin %h step2 pin %h cash %0d need 0 5612 0",
                          rise_pin[rb], rise_pin[rb+1], rise_cash[rb+1]);
      end
      checks++;
      if ((rise_pin[rb+2] !== GOOD_PIN) || (rise_cash[rb+2] !== 14'd2500)) begin
        fails++; $display("FAIL step_cash: pin %h cash %0d need 5612 2500", rise_pin[rb+2], rise_cash[rb+2]);
      end
    end
  endtask

  task automatic test_fast_atm();
    bit got; int cyc;
    atm_lat = 1;
    start_session(GOOD_PIN, 14'd777);
    wait_done(300, got, cyc);
    checks++;
    if (!got || (pass !== 1'b1)) begin
      fails++; $display("FAIL fast_atm_pass: got_done %b pass %b need 1 1", got, pass);
    end
    @(negedge clk);
    checks++;
    if (cash_received !== 14'd777) begin
      fails++; $display("FAIL fast_atm_cash: got %0d need 777", cash_received);
    end
    atm_lat = 4;
  endtask

  task automatic test_abort();
    bit got; bit reached; int cyc; int rb; int cb;
    rb = rise_pin.size(); cb = cancel_rises;
    start_session(GOOD_PIN, 14'd1200);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((rise_pin.size() >= rb + 2) && !atm_next) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin fails++; $display("FAIL abort_reach_wait2: step 2 hold not seen"); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ((atm_cancel !== 1'b1) || (atm_next !== 1'b0)) begin
      fails++; $display("FAIL abort_cancel: cancel %b next %b need 1 0", atm_cancel, atm_next);
    end
    wait_done(200, got, cyc);
    checks++;
    if (!got || (pass !== 1'b0) || (err_step !== 3'd0)) begin
      fails++; $display("FAIL abort_report: done %b pass %b err %0d need 1 0 0", got, pass, err_step);
    end
    checks++;
    if ((atm_state !== 3'd0) || (cancel_rises - cb != 1)) begin
      fails++; $display("FAIL abort_atm: state %0d cancel pulses %0d need 0 1", atm_state, cancel_rises - cb);
    end
    @(negedge clk);
    checks++;
    if ((busy !== 1'b0) || (cash_received !== 14'd0)) begin
      fails++; $display("FAIL abort_after: busy %b cash %0d need 0 0", busy, cash_received);
    end
  endtask

  task automatic test_timeout();
    bit got; int cyc; int rb; int cb; int exp_rises; int lo; int hi;
`ifdef ATM_DRV_RETRY_EN
    exp_rises = 3; lo = 134; hi = 144;
`else
    exp_rises = 2; lo = 70; hi = 80;
`endif
    rb = rise_pin.size(); cb = cancel_rises;
    stuck = 1'b1;
    start_session(GOOD_PIN, 14'd50);
    wait_done(400, got, cyc);
    checks++;
    if (!got || (pass !== 1'b0) || (err_step !== 3'd2)) begin
      fails++; $display("FAIL timeout_report: done %b pass %b err %0d need 1 0 2", got, pass, err_step);
    end
    checks++;
    if ((cyc < lo) || (cyc > hi)) begin
      fails++; $display("FAIL timeout_latency: got %0d cycles need %0d..%0d", cyc, lo, hi);
    end
    checks++;
    if (rise_pin.size() - rb != exp_rises) begin
      fails++; $display("FAIL timeout_next_pulses: got %0d need %0d", rise_pin.size() - rb, exp_rises);
    end
    checks++;
    if (cancel_rises - cb != 1) begin
      fails++; $display("FAIL timeout_cancel: got %0d cancel pulses need 1", cancel_rises - cb);
    end
    stuck = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    bit got; int cyc; int dc; bit seen;
    start_session(GOOD_PIN, 14'd100);
    @(negedge clk);
    req_pin = 16'h1234; req_amount = 14'd999; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(300, got, cyc);
    checks++;
    if (!got || (pass !== 1'b1)) begin
      fails++; $display("FAIL busy_start_pass: done %b pass %b need 1 1", got, pass);
    end
    @(negedge clk);
    checks++;
    if (cash_received !== 14'd100) begin
      fails++; $display("FAIL busy_start_cash: got %0d need 100", cash_received);
    end
    #1 dc = done_cnt;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (busy || atm_next) seen = 1'b1; end
    checks++;
    if (seen || (done_cnt != dc)) begin
      fails++; $display("FAIL busy_start_no_session: activity %b extra dones %0d need 0 0", seen, done_cnt - dc);
    end
    req_pin = GOOD_PIN; req_amount = 14'd300;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (busy || atm_next) seen = 1'b1; end
    checks++;
    if (seen || (done_cnt != dc)) begin
      fails++; $display("FAIL start_abort_idle: activity %b extra dones %0d need 0 0", seen, done_cnt - dc);
    end
  endtask

  task automatic test_reset_mid();
    bit got; bit reached; int cyc; int rb; int dc;
    rb = rise_pin.size();
    start_session(GOOD_PIN, 14'd2500);
    reached = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if ((rise_pin.size() >= rb + 3) && !atm_next) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin fails++; $display("FAIL rst_reach_wait3: step 3 hold not seen"); end
    dc = done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, atm_next, atm_cancel} !== 5'b0) begin
      fails++; $display("FAIL rst_mid_ctrl: got %b need 00000", {busy, done, pass, atm_next, atm_cancel});
    end
    checks++;
    if ((atm_pin !== 16'd0) || (atm_cash_in !== 14'd0) || (cash_received !== 14'd0) || (err_step !== 3'd0)) begin
      fails++; $display("FAIL rst_mid_data: pin %h cash_in %0d cash %0d err %0d need 0",
                        atm_pin, atm_cash_in, cash_received, err_step);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != dc) begin
      fails++; $display("FAIL rst_mid_no_done: got %0d done pulses need 0", done_cnt - dc);
    end
    start_session(GOOD_PIN, 14'd2500);
    wait_done(300, got, cyc);
    checks++;
    if (!got || (pass !== 1'b1)) begin
      fails++; $display("FAIL rst_mid_fresh: done %b pass %b need 1 1", got, pass);
    end
    @(negedge clk);
    checks++;
    if (cash_received !== 14'd2500) begin
      fails++; $display("FAIL rst_mid_fresh_cash: got %0d need 2500", cash_received);
    end
  endtask

  task automatic test_protocol();
    #1;
    checks++;
    if (excl_bad != 0) begin fails++; $display("FAIL next_cancel_excl: %0d overlapping cycles need 0", excl_bad); end
    checks++;
    if ((setup_bad != 0) || (rise_pin.size() == 0)) begin
      fails++; $display("FAIL data_setup: %0d unstable rises of %0d need 0", setup_bad, rise_pin.size());
    end
    checks++;
    if ((len_bad != 0) || (cancel_rises == 0)) begin
      fails++; $display("FAIL hold_length: %0d wrong holds, %0d cancels seen need 0 and >0", len_bad, cancel_rises);
    end
  endtask

  initial begin
    test_reset();
    test_session();
    test_fast_atm();
    test_abort();
    test_timeout();
    test_start_ignored();
    test_reset_mid();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
